// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew: receive-side de-skew for the staggered systolic datapath.
// Lane i arrives i cycles after lane 0. Each lane is delayed by LANES-1-i registers,
// the aligned lane-valids are checked for agreement, and the aligned word is pushed
// into a first-word-fall-through FIFO that is drained with a valid/ready handshake.
// Optional build macro SYSTOLIC_DESKEW_LEVEL_EN adds the fill_level output (FIFO count).
module systolic_output_deskew #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic                     err_skew,
  output logic                     err_overflow,
  input  logic                     clr_err
`ifdef SYSTOLIC_DESKEW_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   fill_level
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = LANES * WIDTH;

  // Aligned lane-valids and data at the delay-line outputs
  logic [LANES-1:0] w_av;
  logic [DW-1:0]    w_ad;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi == LANES - 1) begin : g_pass
        // Last lane arrives latest and needs no delay
        assign w_av[gi]                = in_valid[gi];
        assign w_ad[gi*WIDTH +: WIDTH] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_dly
        localparam int unsigned D = LANES - 1 - gi;
        logic [D-1:0]     r_v;
        logic [WIDTH-1:0] r_d [D];

        // Shift register delaying this lane's valid and data by D cycles
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_v <= '0;
            for (int unsigned j = 0; j < D; j++) r_d[j] <= '0;
          end else begin
            r_v[0] <= in_valid[gi];
            r_d[0] <= in_data[gi*WIDTH +: WIDTH];
            for (int unsigned j = 1; j < D; j++) begin
              r_v[j] <= r_v[j-1];
              r_d[j] <= r_d[j-1];
            end
          end
        end

        assign w_av[gi]                = r_v[D-1];
        assign w_ad[gi*WIDTH +: WIDTH] = r_d[D-1];
      end
    end
  endgenerate

  // FIFO state
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_last;
  logic          r_err_skew;
  logic          r_err_overflow;

  logic w_push_req;
  logic w_skew;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Beat classification and FIFO handshake decode
  always_comb begin
    w_push_req = &w_av;
    w_skew     = (|w_av) & ~(&w_av);
    w_full     = (r_count == CW'(DEPTH));
    w_empty    = (r_count == '0);
    w_pop      = ~w_empty & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    w_push     = w_push_req & (~w_full | w_pop);
    w_drop     = w_push_req & w_full & ~w_pop;
  end

  // FIFO storage write; contents are only observed through the count-qualified head
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_ad;
  end

  // FIFO pointers, count and last-popped word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_last <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_skew     <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_skew)       r_err_skew <= 1'b1;
      else if (clr_err) r_err_skew <= 1'b0;
      if (w_drop)       r_err_overflow <= 1'b1;
      else if (clr_err) r_err_overflow <= 1'b0;
    end
  end

  // When empty the head slot is stale, so show the last popped word instead
  assign out_valid    = ~w_empty;
  assign out_data     = w_empty ? r_last : r_mem[r_rptr];
  assign err_skew     = r_err_skew;
  assign err_overflow = r_err_overflow;

`ifdef SYSTOLIC_DESKEW_LEVEL_EN
  assign fill_level = r_count;
`endif

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Testbench for systolic_output_deskew: directed staggered beats, a queue-based
// reference model of beat alignment and FIFO behaviour, a per-cycle compare process
// and literal spot checks.
module tb_systolic_output_deskew;

  localparam int unsigned LANES = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = LANES * WIDTH;
  localparam int          NB    = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [LANES-1:0] in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          err_skew;
  logic          err_overflow;
  logic          clr_err;
`ifdef SYSTOLIC_DESKEW_LEVEL_EN
  logic [$clog2(DEPTH):0] fill_level;
`endif

  systolic_output_deskew #(
    .LANES(LANES),
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .err_skew    (err_skew),
    .err_overflow(err_overflow),
    .clr_err     (clr_err)
`ifdef SYSTOLIC_DESKEW_LEVEL_EN
    ,
    .fill_level  (fill_level)
`endif
  );

  always #5 clk = ~clk;

  // Beat table indexed by the cycle in which lane 0 of the beat is presented
  logic          beat_on   [NB];
  logic [3:0]    beat_mask [NB];
  logic [31:0]   beat_word [NB];

  int            cyc;
  int            n_checks;
  int            n_err;
  logic          chk_en;

  // Reference model: queue of words held by the FIFO plus flags
  logic [31:0]   mq[$];
  logic [31:0]   mlast;
  logic          m_skew;
  logic          m_ovf;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Drive lane i with lane i of the beat that started i cycles ago
  task automatic apply_inputs(input int c);
    logic [3:0]  v;
    logic [31:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      int k;
      k = c - i;
      if (k >= 0 && beat_on[k]) begin
        v[i] = beat_mask[k][i];
        d[i*WIDTH +: WIDTH] = beat_word[k][i*WIDTH +: WIDTH];
      end
    end
    in_valid = v;
    in_data  = d;
  endtask

  // Model update for edge c: the beat started LANES-1 cycles earlier completes here
  task automatic model_edge(input int c);
    int   k;
    logic preq;
    logic pskew;
    logic pop;
    logic full;
    logic povf;
    if (rst) return;
    k     = c - (int'(LANES) - 1);
    preq  = 1'b0;
    pskew = 1'b0;
    if (k >= 0 && beat_on[k]) begin
      if (beat_mask[k] == 4'hF)      preq  = 1'b1;
      else if (beat_mask[k] != 4'h0) pskew = 1'b1;
    end
    pop  = (mq.size() != 0) && out_ready;
    full = (mq.size() == int'(DEPTH));
    povf = preq && full && !pop;
    if (pop) mlast = mq.pop_front();
    if (preq && !povf) mq.push_back(beat_word[k]);
    if (pskew)        m_skew = 1'b1;
    else if (clr_err) m_skew = 1'b0;
    if (povf)         m_ovf = 1'b1;
    else if (clr_err) m_ovf = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(cyc);
    cyc++;
    #1;
    apply_inputs(cyc);
  endtask

  task automatic sched(input int off, input logic [31:0] word, input logic [3:0] mask);
    beat_on[cyc + off]   = 1'b1;
    beat_word[cyc + off] = word;
    beat_mask[cyc + off] = mask;
    apply_inputs(cyc);
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      check("cmp_out_data", out_data, (mq.size() != 0) ? mq[0] : mlast);
      check("cmp_err_skew", {31'b0, err_skew}, {31'b0, m_skew});
      check("cmp_err_overflow", {31'b0, err_overflow}, {31'b0, m_ovf});
`ifdef SYSTOLIC_DESKEW_LEVEL_EN
      check("cmp_fill_level", {29'b0, fill_level}, 32'(mq.size()));
`endif
    end
  end

  initial begin
    for (int i = 0; i < NB; i++) begin
      beat_on[i]   = 1'b0;
      beat_mask[i] = '0;
      beat_word[i] = '0;
    end
    n_checks  = 0;
    n_err     = 0;
    chk_en    = 1'b0;
    cyc       = 0;
    mq.delete();
    mlast     = '0;
    m_skew    = 1'b0;
    m_ovf     = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    in_valid  = '0;
    in_data   = '0;

    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_err_skew", {31'b0, err_skew}, 32'd0);
    check("reset_err_overflow", {31'b0, err_overflow}, 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    apply_inputs(cyc);

    // Single beat: latency LANES-1 from the lane-0 edge
    sched(0, 32'h44332211, 4'hF);
    repeat (3) tick();
    check("t1_not_yet_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_data", out_data, 32'h44332211);
    check("t1_no_skew", {31'b0, err_skew}, 32'd0);
    tick();
    check("t1_popped", {31'b0, out_valid}, 32'd0);
    check("t1_hold_last", out_data, 32'h44332211);

    // Eight back-to-back beats at full throughput
    repeat (2) tick();
    for (int j = 0; j < 8; j++) sched(j, 32'h01010101 * j, 4'hF);
    repeat (3) tick();
    for (int j = 0; j < 8; j++) begin
      tick();
      check("t2_valid", {31'b0, out_valid}, 32'd1);
      check("t2_word", out_data, 32'h01010101 * j);
    end
    tick();
    check("t2_drained", {31'b0, out_valid}, 32'd0);

    // Overflow with consumer stalled, then drain and clear
    repeat (2) tick();
    out_ready = 1'b0;
    for (int j = 0; j < 6; j++) sched(j, 32'hA0A0A0A0 + 32'h01010101 * j, 4'hF);
    repeat (7) tick();
    check("t3_full_no_ovf", {31'b0, err_overflow}, 32'd0);
    check("t3_head", out_data, 32'hA0A0A0A0);
    tick();
    check("t3_ovf_set", {31'b0, err_overflow}, 32'd1);
    tick();
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick();
      check("t3_drain", out_data, 32'hA0A0A0A0 + 32'h01010101 * j);
    end
    tick();
    check("t3_empty", {31'b0, out_valid}, 32'd0);
    check("t3_last", out_data, 32'hA3A3A3A3);
    check("t3_ovf_sticky", {31'b0, err_overflow}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t3_ovf_cleared", {31'b0, err_overflow}, 32'd0);

    // Full FIFO with simultaneous push and pop
    repeat (2) tick();
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) sched(j, 32'hB0B0B0B0 + 32'h01010101 * j, 4'hF);
    repeat (7) tick();
    check("t4_full_head", out_data, 32'hB0B0B0B0);
    out_ready = 1'b1;
    tick();
    check("t4_no_ovf", {31'b0, err_overflow}, 32'd0);
    check("t4_head_after", out_data, 32'hB1B1B1B1);
`ifdef SYSTOLIC_DESKEW_LEVEL_EN
    check("t4_level_full", {29'b0, fill_level}, 32'd4);
`endif
    for (int j = 2; j < 5; j++) begin
      tick();
      check("t4_drain", out_data, 32'hB0B0B0B0 + 32'h01010101 * j);
    end
    tick();
    check("t4_empty", {31'b0, out_valid}, 32'd0);

    // Skewed beat: lane 2 withheld for the middle beat
    repeat (2) tick();
    sched(0, 32'hC0C0C0C0, 4'hF);
    sched(1, 32'hC1C1C1C1, 4'b1011);
    sched(2, 32'hC2C2C2C2, 4'hF);
    repeat (4) tick();
    check("t5_first", out_data, 32'hC0C0C0C0);
    check("t5_no_skew_yet", {31'b0, err_skew}, 32'd0);
    tick();
    check("t5_skew_set", {31'b0, err_skew}, 32'd1);
    check("t5_skew_no_write", {31'b0, out_valid}, 32'd0);
    tick();
    check("t5_third_valid", {31'b0, out_valid}, 32'd1);
    check("t5_third", out_data, 32'hC2C2C2C2);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_skew_cleared", {31'b0, err_skew}, 32'd0);
    sched(0, 32'hD0D0D0D0, 4'b1011);
    repeat (3) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_set_wins", {31'b0, err_skew}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_skew_cleared2", {31'b0, err_skew}, 32'd0);

    // Reset mid-stream: three words queued, two beats in flight
    repeat (2) tick();
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) sched(j, 32'hE0E0E0E0 + 32'h01010101 * j, 4'hF);
    repeat (6) tick();
    check("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    check("t6_pre_head", out_data, 32'hE0E0E0E0);
    #2;
    rst = 1'b1;
    mq.delete();
    mlast  = '0;
    m_skew = 1'b0;
    m_ovf  = 1'b0;
    for (int i = 0; i < NB; i++) beat_on[i] = 1'b0;
    apply_inputs(cyc);
    #1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_data", out_data, 32'h0);
    check("t6_rst_skew", {31'b0, err_skew}, 32'd0);
    check("t6_rst_ovf", {31'b0, err_overflow}, 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("t6_no_stale", {31'b0, out_valid}, 32'd0);
    check("t6_no_stale_skew", {31'b0, err_skew}, 32'd0);
    sched(0, 32'h5A6B7C8D, 4'hF);
    repeat (3) tick();
    check("t6_fresh_not_yet", {31'b0, out_valid}, 32'd0);
    tick();
    check("t6_fresh_valid", {31'b0, out_valid}, 32'd1);
    check("t6_fresh_data", out_data, 32'h5A6B7C8D);
    tick();
    check("t6_fresh_popped", {31'b0, out_valid}, 32'd0);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
